// File: rtl/cam_pkg.sv
// Shared types and default sizes for the camera frame-capture path.
package cam_pkg;

  localparam int FRAME_PIXELS_DEF = 76800;
  localparam int ADDR_W_DEF       = 17;
  localparam int DATA_W_DEF       = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    COMMIT
  } cap_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/bank_tracker.sv
// Ping-pong bank occupancy: full flags, oldest-unread pointer, commit/ack arbitration.
module bank_tracker
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       commit,
  input  bank_t      commit_bank,
  input  logic       ack,
  output logic [1:0] full,
  output logic       frame_ready,
  output bank_t      rd_bank
);

  logic [1:0] full_q;
  logic [1:0] full_nxt;
  bank_t      oldest;
  logic       ack_ok;

  assign ack_ok = ack & (|full_q);

  // Apply the ack first so a commit into the bank being freed still leaves it full
  always_comb begin
    full_nxt = full_q;
    if (ack_ok) full_nxt[oldest] = 1'b0;
    if (commit) full_nxt[commit_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      oldest <= 1'b0;
    end else begin
      full_q <= full_nxt;
      if (ack_ok) oldest <= ~oldest;
    end
  end

  assign full        = full_q;
  assign frame_ready = |full_q;
  assign rd_bank     = oldest;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Arms frame capture, validates pixel counts and commits whole frames into a two-bank buffer.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DROP_W       = 8
) (
  input  logic              p_clock,
  input  logic              reset,
  input  logic              cap_start,
  input  logic              cap_continuous,
  input  logic              pixel_valid,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_ready,
  output logic              rd_bank,
  input  logic              frame_ack,
  output logic              busy,
  output logic              frame_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_PIXELS);
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(FRAME_PIXELS);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  cap_state_t       state, state_nxt;
  bank_t            wbank;
  logic [CNT_W-1:0] count, cnt_now;
  logic             bad;
  logic [1:0]       full;
  logic             in_cap, reject, accept, frame_ok;
  logic             commit, drop, err_set, wr_stb_p0;

  // A pixel is refused once the frame is already full or its address is out of range
  assign in_cap   = (state == CAPTURE);
  assign reject   = in_cap & pixel_valid &
                    (({1'b0, pixel_addr} >= ADDR_LIM) | (count == CNT_FULL));
  assign accept   = in_cap & pixel_valid & ~reject;
  assign cnt_now  = accept ? count + CNT_W'(1) : count;
  assign frame_ok = (cnt_now == CNT_FULL) & ~(bad | reject);

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cap_start) state_nxt = WAIT_SOF;
      WAIT_SOF: if (frame_done && !full[wbank]) state_nxt = CAPTURE;
      CAPTURE:  if (frame_done) state_nxt = frame_ok ? COMMIT : WAIT_SOF;
      COMMIT: begin
        if (!cap_continuous)  state_nxt = IDLE;
        else if (full[~wbank]) state_nxt = WAIT_SOF;
        else                   state_nxt = CAPTURE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state == COMMIT);
    drop      = (state == WAIT_SOF) & frame_done & full[wbank];
    err_set   = in_cap & frame_done & ~frame_ok;
    wr_stb_p0 = accept;
    busy      = (state != IDLE);
  end

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      count     <= '0;
      bad       <= 1'b0;
      wbank     <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wr_en <= wr_stb_p0;
      if (wr_stb_p0) begin
        wr_addr <= {wbank, pixel_addr};
        wr_data <= pixel_data;
      end
      if (in_cap) begin
        count <= cnt_now;
        bad   <= bad | reject;
      end else begin
        count <= '0;
        bad   <= 1'b0;
      end
      if (commit) wbank <= ~wbank;
      if (err_set)        frame_err <= 1'b1;
      else if (cap_start) frame_err <= 1'b0;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  bank_tracker u_bank_tracker (
    .clk         (p_clock),
    .rst         (reset),
    .commit      (commit),
    .commit_bank (wbank),
    .ack         (frame_ack),
    .full        (full),
    .frame_ready (frame_ready),
    .rd_bank     (rd_bank)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 4-pixel frame.
module tb_frame_capture_ctrl;

  localparam int FP  = 4;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int DRW = 8;

  logic          p_clock = 1'b0;
  logic          reset = 1'b1;
  logic          cap_start = 1'b0;
  logic          cap_continuous = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [DW-1:0] pixel_data = '0;
  logic [AW-1:0] pixel_addr = '0;
  logic          frame_done = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_ready;
  logic          rd_bank;
  logic          busy;
  logic          frame_err;
  logic [DRW-1:0] drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  frame_capture_ctrl #(
    .FRAME_PIXELS (FP),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DROP_W       (DRW)
  ) dut (
    .p_clock        (p_clock),
    .reset          (reset),
    .cap_start      (cap_start),
    .cap_continuous (cap_continuous),
    .pixel_valid    (pixel_valid),
    .pixel_data     (pixel_data),
    .pixel_addr     (pixel_addr),
    .frame_done     (frame_done),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_ready    (frame_ready),
    .rd_bank        (rd_bank),
    .frame_ack      (frame_ack),
    .busy           (busy),
    .frame_err      (frame_err),
    .drop_cnt       (drop_cnt)
  );

  always #5 p_clock = ~p_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge p_clock);
    #1;
    cap_start   = 1'b0;
    frame_ack   = 1'b0;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
  endtask

  task automatic pix(input int a);
    pixel_valid = 1'b1;
    pixel_addr  = AW'(a);
    pixel_data  = DW'(16'hA000 + a);
    tick();
  endtask

  task automatic fdone();
    frame_done = 1'b1;
    tick();
  endtask

  task automatic start();
    cap_start = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge p_clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] waddr(input int bank, input int a);
    logic [AW:0] v;
    v = {bank[0], AW'(a)};
    return 32'(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Single-shot capture into bank 0
    do_reset();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_ready", 32'(frame_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    start();
    check("armed_busy", 32'(busy), 1);
    fdone();
    for (int k = 0; k < 4; k++) begin
      pix(k);
      check("t1_wr_en", 32'(wr_en), 1);
      check("t1_wr_addr", 32'(wr_addr), waddr(0, k));
      check("t1_wr_data", 32'(wr_data), 32'(16'hA000 + k));
    end
    fdone();
    check("t1_commit_wr_en", 32'(wr_en), 0);
    check("t1_commit_ready", 32'(frame_ready), 0);
    tick();
    check("t1_ready", 32'(frame_ready), 1);
    check("t1_rd_bank", 32'(rd_bank), 0);
    check("t1_idle", 32'(busy), 0);
    check("t1_err", 32'(frame_err), 0);

    // Continuous capture with a silent consumer, then overflow drop
    do_reset();
    cap_continuous = 1'b1;
    start();
    fdone();
    for (int k = 0; k < 4; k++) pix(k);
    fdone();
    tick();
    for (int k = 0; k < 4; k++) begin
      pix(k);
      check("t2_b1_addr", 32'(wr_addr), waddr(1, k));
    end
    fdone();
    tick();
    check("t2_ready", 32'(frame_ready), 1);
    check("t2_rd_bank0", 32'(rd_bank), 0);
    for (int k = 0; k < 4; k++) begin
      pix(k);
      check("t2_no_write_full", 32'(wr_en), 0);
    end
    fdone();
    check("t2_drop", 32'(drop_cnt), 1);
    frame_ack = 1'b1;
    tick();
    check("t2_ack_rd_bank", 32'(rd_bank), 1);
    check("t2_ack_ready", 32'(frame_ready), 1);
    fdone();
    for (int k = 0; k < 4; k++) begin
      pix(k);
      check("t2_b0_addr", 32'(wr_addr), waddr(0, k));
    end
    fdone();
    tick();
    check("t2_final_rd_bank", 32'(rd_bank), 1);
    check("t2_final_drop", 32'(drop_cnt), 1);
    cap_continuous = 1'b0;

    // Short frame, error clear while waiting, then retry on the next full frame
    do_reset();
    frame_ack = 1'b1;
    tick();
    check("ack_empty_ready", 32'(frame_ready), 0);
    check("ack_empty_rd_bank", 32'(rd_bank), 0);
    start();
    fdone();
    for (int k = 0; k < 3; k++) pix(k);
    fdone();
    check("t3_err", 32'(frame_err), 1);
    check("t3_busy", 32'(busy), 1);
    tick();
    check("t3_no_commit", 32'(frame_ready), 0);
    start();
    check("t3_err_clear", 32'(frame_err), 0);
    check("t3_still_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) pix(k);
    check("t3_discard", 32'(wr_en), 0);
    fdone();
    for (int k = 0; k < 4; k++) pix(k);
    check("t3_retry_addr", 32'(wr_addr), waddr(0, 3));
    fdone();
    tick();
    check("t3_ready", 32'(frame_ready), 1);
    check("t3_rd_bank", 32'(rd_bank), 0);
    check("t3_idle", 32'(busy), 0);

    // Long frame: fifth pixel suppressed
    do_reset();
    start();
    fdone();
    for (int k = 0; k < 4; k++) pix(k);
    pix(4);
    check("t4_suppress", 32'(wr_en), 0);
    check("t4_addr_hold", 32'(wr_addr), waddr(0, 3));
    fdone();
    check("t4_err", 32'(frame_err), 1);
    tick();
    check("t4_no_commit", 32'(frame_ready), 0);

    // Ack lands in the same cycle as a commit
    do_reset();
    start();
    fdone();
    for (int k = 0; k < 4; k++) pix(k);
    fdone();
    tick();
    start();
    fdone();
    pix(0);
    check("t5_b1_addr", 32'(wr_addr), waddr(1, 0));
    for (int k = 1; k < 4; k++) pix(k);
    fdone();
    frame_ack = 1'b1;
    tick();
    check("t5_ready", 32'(frame_ready), 1);
    check("t5_rd_bank", 32'(rd_bank), 1);
    check("t5_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a capture
    start();
    fdone();
    pix(0);
    pix(1);
    check("t6_pre_wr_en", 32'(wr_en), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_wr_en", 32'(wr_en), 0);
    check("t6_rst_addr", 32'(wr_addr), 0);
    check("t6_rst_ready", 32'(frame_ready), 0);
    check("t6_rst_rd_bank", 32'(rd_bank), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(negedge p_clock);
    reset = 1'b0;
    tick();
    check("t6_post_ready", 32'(frame_ready), 0);
    check("t6_post_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
